// File: rtl/calcu16_pkg.sv
// Shared constants, types and loader state encoding for the calcu16 program loader.
package calcu16_pkg;

    localparam int unsigned WORD_WIDTH     = 26;
    localparam int unsigned ADDR_WIDTH     = 16;
    localparam int unsigned LEN_WIDTH      = 16;
    localparam int unsigned BYTE_WIDTH     = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_WIDTH      = 2;
    localparam int unsigned HOLD_WIDTH     = (BYTES_PER_WORD - 1) * BYTE_WIDTH;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [LEN_WIDTH-1:0]  len_t;
    typedef logic [BYTE_WIDTH-1:0] byte_t;

    typedef struct packed {
        addr_t addr;
        word_t data;
    } mem_wr_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Shifts data bytes MSB-first into an instruction word, counts bytes per word
// and keeps the running XOR checksum of every data byte.
module word_assembler
    import calcu16_pkg::*;
(
    input  logic  clk,
    input  logic  resetN,
    input  logic  i_clear,
    input  logic  i_shift,
    input  byte_t i_byte,
    output word_t o_word_c,
    output logic  o_word_ready_c,
    output byte_t o_chk
);

    logic [HOLD_WIDTH-1:0] r_hold;
    logic [CNT_WIDTH-1:0]  r_cnt;
    byte_t                 r_chk;

    // The 4th byte completes the word combinationally so the write can be launched on the same edge.
    assign o_word_c       = WORD_WIDTH'({r_hold, i_byte});
    assign o_word_ready_c = i_shift && (r_cnt == CNT_WIDTH'(BYTES_PER_WORD - 1));
    assign o_chk          = r_chk;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hold <= '0;
            r_cnt  <= '0;
            r_chk  <= '0;
        end else if (i_clear) begin
            r_hold <= '0;
            r_cnt  <= '0;
            r_chk  <= '0;
        end else if (i_shift) begin
            r_hold <= {r_hold[HOLD_WIDTH-BYTE_WIDTH-1:0], i_byte};
            r_cnt  <= r_cnt + CNT_WIDTH'(1);
            r_chk  <= r_chk ^ i_byte;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: parses length/address header, writes assembled
// words to instruction RAM and holds the CPU until the checksum byte is judged.
module program_loader
    import calcu16_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] rxData,
    input  logic                  rxValid,
    output logic                  rxReady,
    output logic                  memLoad,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [WORD_WIDTH-1:0] memDataIn,
    output logic                  cpuHold,
    output logic                  done,
    output logic                  error
);

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic    r_rx_ready;
    logic    r_mem_load;
    logic    r_cpu_hold;
    logic    r_done;
    logic    r_error;
    mem_wr_t r_mem_wr;
    addr_t   r_addr;
    len_t    r_remaining;

    logic    w_accept;
    logic    w_clear;
    logic    w_shift;
    logic    w_rx_ready_nxt;
    logic    w_cpu_hold_nxt;
    word_t   w_word;
    logic    w_word_ready;
    byte_t   w_chk;

    assign w_accept = rxValid && r_rx_ready;
    assign w_clear  = (r_state == ST_IDLE) && start;
    assign w_shift  = (r_state == ST_DATA) && w_accept;

    word_assembler u_word_assembler (
        .clk            (clk),
        .resetN         (resetN),
        .i_clear        (w_clear),
        .i_shift        (w_shift),
        .i_byte         (rxData),
        .o_word_c       (w_word),
        .o_word_ready_c (w_word_ready),
        .o_chk          (w_chk)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the state-decoded outputs, registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_rx_ready_nxt = 1'b0;
        w_cpu_hold_nxt = 1'b0;
        case (r_state)
            ST_IDLE:    if (start)    w_state_nxt = ST_LEN_HI;
            ST_LEN_HI:  if (w_accept) w_state_nxt = ST_LEN_LO;
            ST_LEN_LO:  if (w_accept) w_state_nxt = ST_ADDR_HI;
            ST_ADDR_HI: if (w_accept) w_state_nxt = ST_ADDR_LO;
            ST_ADDR_LO: begin
                if (w_accept) begin
                    w_state_nxt = (r_remaining == '0) ? ST_CHECK : ST_DATA;
                end
            end
            ST_DATA:    if (w_word_ready) w_state_nxt = ST_WRITE;
            ST_WRITE:   w_state_nxt = (r_remaining == '0) ? ST_CHECK : ST_DATA;
            ST_CHECK: begin
                if (w_accept) begin
                    w_state_nxt = (rxData == w_chk) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE:    w_state_nxt = ST_IDLE;
            ST_ERROR:   w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        case (w_state_nxt)
            ST_LEN_HI, ST_LEN_LO, ST_ADDR_HI, ST_ADDR_LO, ST_DATA, ST_CHECK: begin
                w_rx_ready_nxt = 1'b1;
                w_cpu_hold_nxt = 1'b1;
            end
            ST_WRITE: w_cpu_hold_nxt = 1'b1;
            default: begin
                w_rx_ready_nxt = 1'b0;
                w_cpu_hold_nxt = 1'b0;
            end
        endcase
    end

    // Header capture, write launch and address/count bookkeeping.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rx_ready  <= 1'b0;
            r_mem_load  <= 1'b0;
            r_cpu_hold  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_mem_wr    <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            r_rx_ready <= w_rx_ready_nxt;
            r_cpu_hold <= w_cpu_hold_nxt;
            r_mem_load <= (w_state_nxt == ST_WRITE);
            if (w_clear) begin
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end else if (w_state_nxt == ST_DONE) begin
                r_done  <= 1'b1;
            end else if (w_state_nxt == ST_ERROR) begin
                r_error <= 1'b1;
            end
            if (w_accept) begin
                case (r_state)
                    ST_LEN_HI:  r_remaining[LEN_WIDTH-1 -: BYTE_WIDTH]  <= rxData;
                    ST_LEN_LO:  r_remaining[BYTE_WIDTH-1:0]             <= rxData;
                    ST_ADDR_HI: r_addr[ADDR_WIDTH-1 -: BYTE_WIDTH]      <= rxData;
                    ST_ADDR_LO: r_addr[BYTE_WIDTH-1:0]                  <= rxData;
                    default: ;
                endcase
            end
            if (w_word_ready) begin
                r_mem_wr.addr <= r_addr;
                r_mem_wr.data <= w_word;
                r_addr        <= r_addr + ADDR_WIDTH'(1);
                r_remaining   <= r_remaining - LEN_WIDTH'(1);
            end
        end
    end

    assign rxReady    = r_rx_ready;
    assign memLoad    = r_mem_load;
    assign memAddress = r_mem_wr.addr;
    assign memDataIn  = r_mem_wr.data;
    assign cpuHold    = r_cpu_hold;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed frame vectors for program_loader, checked against hand-computed results.
module tb_program_loader;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        memLoad;
    logic [15:0] memAddress;
    logic [25:0] memDataIn;
    logic        cpuHold;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    logic [15:0] q_addr[$];
    logic [25:0] q_data[$];

    typedef struct {
        logic [15:0] len;
        logic [15:0] addr;
        logic [31:0] words[3];
        logic [7:0]  chk;
        bit          rand_gap;
        bit          start_mid;
        logic        exp_done;
        logic        exp_error;
        int          exp_writes;
    } vec_t;

    vec_t tbl[6];

    program_loader dut (
        .clk        (clk),
        .resetN     (resetN),
        .start      (start),
        .rxData     (rxData),
        .rxValid    (rxValid),
        .rxReady    (rxReady),
        .memLoad    (memLoad),
        .memAddress (memAddress),
        .memDataIn  (memDataIn),
        .cpuHold    (cpuHold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (memLoad) begin
            q_addr.push_back(memAddress);
            q_data.push_back(memDataIn);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  n;
        bit  got;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rxValid = 1'b1;
        rxData  = b;
        n   = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (rxReady === 1'b1) got = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        rxValid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout: byte 0x%0h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic int gap_of(input vec_t v);
        return v.rand_gap ? int'($urandom_range(0, 5)) : 0;
    endfunction

    task automatic run_frame(input vec_t v, input int idx);
        logic [31:0] w;
        q_addr.delete();
        q_data.delete();
        pulse_start();
        @(negedge clk);
        check($sformatf("v%0d_hold_on_start", idx), 32'(cpuHold), 32'd1);
        check($sformatf("v%0d_done_cleared", idx), 32'(done), 32'd0);
        check($sformatf("v%0d_error_cleared", idx), 32'(error), 32'd0);
        @(posedge clk);
        #1;
        send_byte(v.len[15:8], gap_of(v));
        send_byte(v.len[7:0], gap_of(v));
        send_byte(v.addr[15:8], gap_of(v));
        send_byte(v.addr[7:0], gap_of(v));
        for (int i = 0; i < int'(v.len); i++) begin
            w = v.words[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*(3-b) +: 8], gap_of(v));
                if (v.start_mid && i == 0 && b == 1) begin
                    pulse_start();
                    check($sformatf("v%0d_hold_after_mid_start", idx), 32'(cpuHold), 32'd1);
                end
            end
        end
        send_byte(v.chk, gap_of(v));
        check($sformatf("v%0d_done", idx), 32'(done), 32'(v.exp_done));
        check($sformatf("v%0d_error", idx), 32'(error), 32'(v.exp_error));
        check($sformatf("v%0d_hold_dropped", idx), 32'(cpuHold), 32'd0);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_idle_not_ready", idx), 32'(rxReady), 32'd0);
        check($sformatf("v%0d_done_held", idx), 32'(done), 32'(v.exp_done));
        check($sformatf("v%0d_error_held", idx), 32'(error), 32'(v.exp_error));
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("v%0d_write_count", idx), 32'(q_addr.size()), 32'(v.exp_writes));
        for (int i = 0; i < v.exp_writes && i < q_addr.size(); i++) begin
            w = v.words[i];
            check($sformatf("v%0d_w%0d_addr", idx, i), 32'(q_addr[i]), 32'(16'(v.addr + 16'(i))));
            check($sformatf("v%0d_w%0d_data", idx, i), 32'(q_data[i]), 32'(w[25:0]));
        end
    endtask

    initial begin
        resetN  = 1'b0;
        start   = 1'b0;
        rxData  = 8'h00;
        rxValid = 1'b0;

        // N=1 @0x0010: 00^12^34^56 = 70
        tbl[0] = '{len: 16'd1, addr: 16'h0010, words: '{32'h00123456, 32'h0, 32'h0}, chk: 8'h70,
                   rand_gap: 1'b0, start_mid: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_writes: 1};
        // N=3 @0xFFFE, address wraps; checksum 04^00^FD = F9
        tbl[1] = '{len: 16'd3, addr: 16'hFFFE, words: '{32'h01020304, 32'h0A0B0C0D, 32'hFC000001},
                   chk: 8'hF9, rand_gap: 1'b1, start_mid: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_writes: 3};
        // N=2, correct checksum 03 sent as 02
        tbl[2] = '{len: 16'd2, addr: 16'h0100, words: '{32'h00000001, 32'h00000002, 32'h0}, chk: 8'h02,
                   rand_gap: 1'b0, start_mid: 1'b0, exp_done: 1'b0, exp_error: 1'b1, exp_writes: 2};
        tbl[3] = '{len: 16'd0, addr: 16'h1234, words: '{32'h0, 32'h0, 32'h0}, chk: 8'h00,
                   rand_gap: 1'b0, start_mid: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_writes: 0};
        tbl[4] = '{len: 16'd0, addr: 16'h1234, words: '{32'h0, 32'h0, 32'h0}, chk: 8'h01,
                   rand_gap: 1'b0, start_mid: 1'b0, exp_done: 1'b0, exp_error: 1'b1, exp_writes: 0};
        // start mid-DATA must be ignored: AA^BB^CC^DD = 00
        tbl[5] = '{len: 16'd1, addr: 16'h0020, words: '{32'hAABBCCDD, 32'h0, 32'h0}, chk: 8'h00,
                   rand_gap: 1'b0, start_mid: 1'b1, exp_done: 1'b1, exp_error: 1'b0, exp_writes: 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rxReady", 32'(rxReady), 32'd0);
        check("rst_memLoad", 32'(memLoad), 32'd0);
        check("rst_cpuHold", 32'(cpuHold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_memAddress", 32'(memAddress), 32'd0);
        check("rst_memDataIn", 32'(memDataIn), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i], i);
        end

        // rxValid high while idle: nothing accepted, nothing written, done held.
        q_addr.delete();
        q_data.delete();
        rxValid = 1'b1;
        rxData  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("idle_valid_ready_%0d", i), 32'(rxReady), 32'd0);
        end
        @(posedge clk);
        #1;
        rxValid = 1'b0;
        check("idle_valid_no_write", 32'(q_addr.size()), 32'd0);
        check("idle_valid_done_held", 32'(done), 32'd1);
        check("idle_valid_hold_low", 32'(cpuHold), 32'd0);

        // Reset after the 2nd data byte of an N=2 frame, then a clean frame.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        q_addr.delete();
        q_data.delete();
        resetN = 1'b0;
        #2;
        check("midrst_rxReady", 32'(rxReady), 32'd0);
        check("midrst_cpuHold", 32'(cpuHold), 32'd0);
        check("midrst_memLoad", 32'(memLoad), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_memAddress", 32'(memAddress), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_stray_write", 32'(q_addr.size()), 32'd0);
        run_frame(tbl[0], 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
